// File: rtl/fetch_stage.sv
// Instruction fetch stage for the pipelined RV32I core.
// Owns the PC, drives the instruction memory address and captures the
// returned word into the IF/ID pipeline register. Downstream logic can
// stall, flush or redirect the stage. A BOOT/RUN/HALT FSM inserts one
// bubble after reset and freezes the stage on halt or a misaligned target.

module fetch_stage #(
    parameter int unsigned                ADDRESS_WIDTH = 32,
    parameter int unsigned                INSTR_WIDTH   = 32,
    parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = '0,
    parameter logic [INSTR_WIDTH-1:0]     NOP_INSTR     = 32'h0000_0013,
    parameter int unsigned                COUNT_WIDTH   = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     stall_i,
    input  logic                     flush_i,
    input  logic                     redirect_i,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc_i,
    input  logic                     halt_i,
    output logic [ADDRESS_WIDTH-1:0] imem_addr_o,
    input  logic [INSTR_WIDTH-1:0]   imem_rdata_i,
    output logic [INSTR_WIDTH-1:0]   if_id_instr_o,
    output logic [ADDRESS_WIDTH-1:0] if_id_pc_o,
    output logic [ADDRESS_WIDTH-1:0] if_id_pc_plus4_o,
    output logic                     if_id_valid_o,
    output logic                     misalign_o,
    output logic [COUNT_WIDTH-1:0]   fetch_count_o
);

    typedef enum logic [1:0] {
        StBoot = 2'b00,
        StRun  = 2'b01,
        StHalt = 2'b10
    } state_e;

    state_e                   state_q;
    logic [ADDRESS_WIDTH-1:0] pc_q;
    logic [ADDRESS_WIDTH-1:0] pc_plus4;
    logic                     target_misaligned;

    // Sequential PC increment; wraps naturally at 2^ADDRESS_WIDTH.
    always_comb begin
        pc_plus4          = pc_q + ADDRESS_WIDTH'(4);
        target_misaligned = (redirect_pc_i[1:0] != 2'b00);
        imem_addr_o       = pc_q;
    end

    // Control FSM plus PC, IF/ID register, misalign flag and fetch counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= StBoot;
            pc_q             <= RESET_PC;
            if_id_instr_o    <= NOP_INSTR;
            if_id_pc_o       <= '0;
            if_id_pc_plus4_o <= '0;
            if_id_valid_o    <= 1'b0;
            misalign_o       <= 1'b0;
            fetch_count_o    <= '0;
        end else begin
            unique case (state_q)
                StBoot: begin
                    // One bubble after reset; memory output is ignored.
                    state_q <= StRun;
                end
                StRun: begin
                    if (halt_i) begin
                        state_q       <= StHalt;
                        if_id_instr_o <= NOP_INSTR;
                        if_id_valid_o <= 1'b0;
                    end else if (redirect_i && target_misaligned) begin
                        // Bad target: freeze the stage rather than fetch garbage.
                        misalign_o    <= 1'b1;
                        state_q       <= StHalt;
                        if_id_instr_o <= NOP_INSTR;
                        if_id_valid_o <= 1'b0;
                    end else if (redirect_i) begin
                        // Redirect wins over stall for both PC and IF/ID.
                        pc_q          <= redirect_pc_i;
                        if_id_instr_o <= NOP_INSTR;
                        if_id_valid_o <= 1'b0;
                    end else if (flush_i) begin
                        if_id_instr_o <= NOP_INSTR;
                        if_id_valid_o <= 1'b0;
                        if (!stall_i) begin
                            pc_q <= pc_plus4;
                        end
                    end else if (!stall_i) begin
                        if_id_instr_o    <= imem_rdata_i;
                        if_id_pc_o       <= pc_q;
                        if_id_pc_plus4_o <= pc_plus4;
                        if_id_valid_o    <= 1'b1;
                        pc_q             <= pc_plus4;
                        fetch_count_o    <= fetch_count_o + COUNT_WIDTH'(1);
                    end
                end
                StHalt: begin
                    // Frozen until reset; keep presenting a bubble.
                    if_id_instr_o <= NOP_INSTR;
                    if_id_valid_o <= 1'b0;
                end
                default: begin
                    state_q       <= StHalt;
                    if_id_instr_o <= NOP_INSTR;
                    if_id_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a behavioural model compared every
// cycle, plus directed literal checks of the key scenarios.

module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        halt = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
    logic        misalign;
    logic [31:0] count;

    // Second instance exercising the PC wrap from a high reset vector.
    logic        rst2_n = 1'b0;
    logic        zero = 1'b0;
    logic [31:0] zero_pc = '0;
    logic [31:0] addr2;
    logic [31:0] rdata2;
    logic [31:0] instr2;
    logic [31:0] pc2;
    logic [31:0] pc4_2;
    logic        valid2;
    logic        misalign2;
    logic [31:0] count2;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    // Instruction memory contents: two fixed words, otherwise derived from the address.
    function automatic logic [31:0] imem(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        if (a == 32'h4) return 32'h00A0_0113;
        return {a[23:0], 8'h33};
    endfunction

    assign imem_rdata = imem(imem_addr);
    assign rdata2     = imem(addr2);

    fetch_stage dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall_i          (stall),
        .flush_i          (flush),
        .redirect_i       (redirect),
        .redirect_pc_i    (redirect_pc),
        .halt_i           (halt),
        .imem_addr_o      (imem_addr),
        .imem_rdata_i     (imem_rdata),
        .if_id_instr_o    (instr),
        .if_id_pc_o       (pc),
        .if_id_pc_plus4_o (pc4),
        .if_id_valid_o    (valid),
        .misalign_o       (misalign),
        .fetch_count_o    (count)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk              (clk),
        .rst_n            (rst2_n),
        .stall_i          (zero),
        .flush_i          (zero),
        .redirect_i       (zero),
        .redirect_pc_i    (zero_pc),
        .halt_i           (zero),
        .imem_addr_o      (addr2),
        .imem_rdata_i     (rdata2),
        .if_id_instr_o    (instr2),
        .if_id_pc_o       (pc2),
        .if_id_pc_plus4_o (pc4_2),
        .if_id_valid_o    (valid2),
        .misalign_o       (misalign2),
        .fetch_count_o    (count2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase flags instead of a state code.
    logic        m_booting;
    logic        m_halted;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    logic [31:0] m_ipc4;
    logic        m_valid;
    logic        m_mis;
    int unsigned m_count;

    // Model update on each active edge using the spec's priority rules.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_booting <= 1'b1;
            m_halted  <= 1'b0;
            m_pc      <= 32'h0;
            m_instr   <= NOP;
            m_ipc     <= 32'h0;
            m_ipc4    <= 32'h0;
            m_valid   <= 1'b0;
            m_mis     <= 1'b0;
            m_count   <= 0;
        end else if (m_booting) begin
            m_booting <= 1'b0;
        end else if (m_halted || halt || (redirect && redirect_pc[1:0] != 2'd0)) begin
            m_halted <= 1'b1;
            m_instr  <= NOP;
            m_valid  <= 1'b0;
            if (!m_halted && !halt) m_mis <= 1'b1;
        end else if (redirect || flush) begin
            m_instr <= NOP;
            m_valid <= 1'b0;
            m_pc    <= redirect ? redirect_pc : (stall ? m_pc : m_pc + 32'd4);
        end else if (!stall) begin
            m_instr <= imem(m_pc);
            m_ipc   <= m_pc;
            m_ipc4  <= m_pc + 32'd4;
            m_valid <= 1'b1;
            m_pc    <= m_pc + 32'd4;
            m_count <= m_count + 1;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("m_addr", imem_addr, m_pc);
        chk("m_valid", {31'd0, valid}, {31'd0, m_valid});
        chk("m_instr", instr, m_instr);
        chk("m_mis", {31'd0, misalign}, {31'd0, m_mis});
        chk("m_count", count, m_count);
        if (m_valid) begin
            chk("m_pc", pc, m_ipc);
            chk("m_pc4", pc4, m_ipc4);
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("rst_instr", instr, NOP);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_pc4", pc4, 32'd0);
        chk("rst_count", count, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_mis", {31'd0, misalign}, 32'd0);
        chk("rst2_addr", addr2, 32'hFFFF_FFFC);
        rst_n  = 1'b1;
        rst2_n = 1'b1;

        // Boot bubble, then two captures.
        cyc();
        chk("boot_valid", {31'd0, valid}, 32'd0);
        chk("boot_addr", imem_addr, 32'd0);
        chk("boot2_valid", {31'd0, valid2}, 32'd0);
        cyc();
        chk("c1_instr", instr, 32'h0050_0093);
        chk("c1_pc", pc, 32'd0);
        chk("c1_pc4", pc4, 32'd4);
        chk("c1_valid", {31'd0, valid}, 32'd1);
        chk("wrap_pc", pc2, 32'hFFFF_FFFC);
        chk("wrap_pc4", pc4_2, 32'd0);
        chk("wrap_addr", addr2, 32'd0);
        cyc();
        chk("c2_instr", instr, 32'h00A0_0113);
        chk("c2_pc", pc, 32'd4);
        chk("c2_count", count, 32'd2);
        chk("wrap_next_pc", pc2, 32'd0);
        chk("wrap_next_instr", instr2, 32'h0050_0093);

        // Two-cycle stall at PC=8.
        stall = 1'b1;
        repeat (2) begin
            cyc();
            chk("stall_addr", imem_addr, 32'd8);
            chk("stall_pc", pc, 32'd4);
            chk("stall_valid", {31'd0, valid}, 32'd1);
            chk("stall_count", count, 32'd2);
        end
        stall = 1'b0;
        cyc();
        chk("unstall_pc", pc, 32'd8);
        chk("unstall_instr", instr, 32'h0000_0833);
        cyc();
        chk("pc10_addr", imem_addr, 32'h10);

        // Redirect with flush and stall all asserted.
        redirect = 1'b1;
        flush = 1'b1;
        stall = 1'b1;
        redirect_pc = 32'h40;
        cyc();
        redirect = 1'b0;
        flush = 1'b0;
        stall = 1'b0;
        chk("redir_addr", imem_addr, 32'h40);
        chk("redir_valid", {31'd0, valid}, 32'd0);
        chk("redir_instr", instr, NOP);
        cyc();
        chk("tgt_pc", pc, 32'h40);
        chk("tgt_valid", {31'd0, valid}, 32'd1);
        chk("tgt_count", count, 32'd5);

        // Misaligned redirect halts the stage.
        redirect = 1'b1;
        redirect_pc = 32'h42;
        cyc();
        redirect = 1'b0;
        chk("mis_flag", {31'd0, misalign}, 32'd1);
        chk("mis_addr", imem_addr, 32'h44);
        repeat (10) begin
            cyc();
            chk("halt_valid", {31'd0, valid}, 32'd0);
            chk("halt_addr", imem_addr, 32'h44);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mis_clear", {31'd0, misalign}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        chk("reboot_valid", {31'd0, valid}, 32'd0);
        cyc();
        chk("reboot_pc", pc, 32'd0);
        chk("reboot_valid1", {31'd0, valid}, 32'd1);

        // Flush without stall advances the PC.
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("flush_valid", {31'd0, valid}, 32'd0);
        chk("flush_addr", imem_addr, 32'd8);
        cyc();
        cyc();

        // Halt, then asynchronous reset mid-cycle.
        halt = 1'b1;
        cyc();
        halt = 1'b0;
        chk("halt_v", {31'd0, valid}, 32'd0);
        cyc();
        chk("halt_frozen", imem_addr, 32'h10);
        chk("halt_count", count, 32'd3);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_addr", imem_addr, 32'd0);
        chk("async_count", count, 32'd0);
        chk("async_instr", instr, NOP);
        chk("async_valid", {31'd0, valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        chk("restart_boot", {31'd0, valid}, 32'd0);
        cyc();
        chk("restart_instr", instr, 32'h0050_0093);
        chk("restart_valid", {31'd0, valid}, 32'd1);
        repeat (3) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
